// File: rtl/latch_write_arbiter.sv
// rtl/latch_write_arbiter.sv - round-robin sequencer sharing one latch write port
// Grants one requester, holds the latch open OPEN_CYC cycles, then closes with a data-hold cycle.
module latch_write_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DW       = 8,
  parameter int OPEN_CYC = 2
) (
  input  logic                clk,
  input  logic                rest,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] wdata,
  output logic [N_REQ-1:0]    gnt,
  output logic [N_REQ-1:0]    done,
  output logic                lat_en,
  output logic [DW-1:0]       lat_d,
  output logic                busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [3:0]    CNT_INIT = 4'(OPEN_CYC - 1);
  localparam logic [PW-1:0] LAST     = PW'(N_REQ - 1);
  localparam logic [PW-1:0] ONE      = PW'(1);

  typedef enum logic [1:0] {IDLE, OPEN, CLOSE} state_e;

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic [PW-1:0]      ptr_q;
  logic [PW-1:0]      win_q;
  logic [N_REQ-1:0]   gnt_q;
  logic [N_REQ-1:0]   done_q;
  logic               lat_en_q;
  logic [DW-1:0]      lat_d_q;

  logic [PW-1:0]      win_d;
  logic               win_vld_d;
  logic [PW-1:0]      scan;
  logic [N_REQ-1:0]   gnt_d;
  logic [DW-1:0]      dat_d;

  // Walk ptr, ptr+1, ... with explicit wrap so non-power-of-two N_REQ works.
  always_comb begin
    win_d     = ptr_q;
    win_vld_d = 1'b0;
    scan      = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      if (!win_vld_d && req[scan]) begin
        win_vld_d = 1'b1;
        win_d     = scan;
      end
      scan = (scan == LAST) ? '0 : scan + ONE;
    end
  end

  always_comb begin
    gnt_d = '0;
    dat_d = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win_d == PW'(i)) begin
        gnt_d[i] = 1'b1;
        dat_d    = wdata[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      win_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      lat_en_q <= 1'b0;
      lat_d_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q   <= '0;
          gnt_q    <= '0;
          lat_en_q <= 1'b0;
          if (win_vld_d) begin
            gnt_q    <= gnt_d;
            win_q    <= win_d;
            lat_d_q  <= dat_d;
            lat_en_q <= 1'b1;
            cnt_q    <= CNT_INIT;
            state_q  <= OPEN;
          end
        end
        OPEN: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            lat_en_q <= 1'b0;
            done_q   <= gnt_q;
            ptr_q    <= (win_q == LAST) ? '0 : win_q + ONE;
            state_q  <= CLOSE;
          end
        end
        CLOSE: begin
          // lat_d_q is left untouched so data outlives the falling enable.
          done_q  <= '0;
          gnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign done   = done_q;
  assign lat_en = lat_en_q;
  assign lat_d  = lat_d_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_latch_write_arbiter.sv
// tb/tb_latch_write_arbiter.sv - directed self-checking bench for latch_write_arbiter
module tb_latch_write_arbiter;

  logic        clk;
  logic        rest;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic        lat_en;
  logic [7:0]  lat_d;
  logic        busy;
  logic [17:0] obs;

  int checks;
  int errors;

  latch_write_arbiter #(.N_REQ(4), .DW(8), .OPEN_CYC(2)) dut (
    .clk    (clk),
    .rest   (rest),
    .req    (req),
    .wdata  (wdata),
    .gnt    (gnt),
    .done   (done),
    .lat_en (lat_en),
    .lat_d  (lat_d),
    .busy   (busy)
  );

  assign obs = {gnt, done, lat_en, busy, lat_d};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] pk(logic [3:0] g, logic [3:0] d, logic e, logic b, logic [7:0] dat);
    return {g, d, e, b, dat};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    req   = 4'b1111;
    wdata = 32'hDEADBEEF;
    checks++;
    if (obs !== 18'h0) begin
      errors++;
      $display("FAIL reset t=0: got %h expected %h", obs, 18'h0);
    end
    for (int t = 1; t <= 3; t++) begin
      tick();
      checks++;
      if (obs !== 18'h0) begin
        errors++;
        $display("FAIL reset t=%0d: got %h expected %h", t, obs, 18'h0);
      end
    end
    req  = 4'b0000;
    rest = 1'b0;
  endtask

  task automatic test_single();
    logic [17:0] exp [1:4];
    exp[1] = pk(4'b0100, 4'b0000, 1'b1, 1'b1, 8'hA5);
    exp[2] = pk(4'b0100, 4'b0000, 1'b1, 1'b1, 8'hA5);
    exp[3] = pk(4'b0100, 4'b0100, 1'b0, 1'b1, 8'hA5);
    exp[4] = pk(4'b0000, 4'b0000, 1'b0, 1'b0, 8'hA5);
    wdata = {8'h44, 8'hA5, 8'h22, 8'h11};
    req   = 4'b0100;
    for (int t = 1; t <= 4; t++) begin
      tick();
      checks++;
      if (obs !== exp[t]) begin
        errors++;
        $display("FAIL single t=%0d: got %h expected %h", t, obs, exp[t]);
      end
      if (t == 3) req = 4'b0000;
    end
  endtask

  task automatic test_reset_mid_open();
    req   = 4'b0010;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    tick();
    checks++;
    if (obs !== pk(4'b0010, 4'b0000, 1'b1, 1'b1, 8'h22)) begin
      errors++;
      $display("FAIL midrst_grant: got %h expected %h", obs, pk(4'b0010, 4'b0000, 1'b1, 1'b1, 8'h22));
    end
    req = 4'b0000;
    #3;
    rest = 1'b1;
    #1;
    checks++;
    if (obs !== 18'h0) begin
      errors++;
      $display("FAIL midrst_async: got %h expected %h", obs, 18'h0);
    end
    for (int t = 1; t <= 2; t++) begin
      tick();
      checks++;
      if (obs !== 18'h0) begin
        errors++;
        $display("FAIL midrst_hold t=%0d: got %h expected %h", t, obs, 18'h0);
      end
    end
    rest = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [7:0]  lane [4];
    logic [3:0]  oh;
    logic [17:0] e;
    int          n, ph, w;
    lane[0] = 8'hA0; lane[1] = 8'hB1; lane[2] = 8'hC2; lane[3] = 8'hD3;
    wdata = {lane[3], lane[2], lane[1], lane[0]};
    req   = 4'b1111;
    for (int t = 1; t <= 20; t++) begin
      tick();
      n  = (t - 1) / 4;
      ph = (t - 1) % 4;
      w  = n % 4;
      oh = 4'b0001 << w;
      case (ph)
        0, 1:    e = pk(oh, 4'b0000, 1'b1, 1'b1, lane[w]);
        2:       e = pk(oh, oh, 1'b0, 1'b1, lane[w]);
        default: e = pk(4'b0000, 4'b0000, 1'b0, 1'b0, lane[w]);
      endcase
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL round_robin t=%0d: got %h expected %h", t, obs, e);
      end
      if (t == 19) req = 4'b0000;
    end
  endtask

  task automatic test_data_capture();
    logic [17:0] exp [1:4];
    exp[1] = pk(4'b0100, 4'b0000, 1'b1, 1'b1, 8'hA5);
    exp[2] = pk(4'b0100, 4'b0000, 1'b1, 1'b1, 8'hA5);
    exp[3] = pk(4'b0100, 4'b0100, 1'b0, 1'b1, 8'hA5);
    exp[4] = pk(4'b0000, 4'b0000, 1'b0, 1'b0, 8'hA5);
    wdata = {8'h77, 8'hA5, 8'h66, 8'h55};
    req   = 4'b0100;
    for (int t = 1; t <= 4; t++) begin
      tick();
      checks++;
      if (obs !== exp[t]) begin
        errors++;
        $display("FAIL capture t=%0d: got %h expected %h", t, obs, exp[t]);
      end
      if (t == 1) wdata[23:16] = 8'h3C;
      if (t == 3) req = 4'b0000;
    end
  endtask

  task automatic test_skip_wrap();
    logic [17:0] exp [1:8];
    exp[1] = pk(4'b0001, 4'b0000, 1'b1, 1'b1, 8'h11);
    exp[2] = pk(4'b0001, 4'b0000, 1'b1, 1'b1, 8'h11);
    exp[3] = pk(4'b0001, 4'b0001, 1'b0, 1'b1, 8'h11);
    exp[4] = pk(4'b0000, 4'b0000, 1'b0, 1'b0, 8'h11);
    exp[5] = pk(4'b0010, 4'b0000, 1'b1, 1'b1, 8'h22);
    exp[6] = pk(4'b0010, 4'b0000, 1'b1, 1'b1, 8'h22);
    exp[7] = pk(4'b0010, 4'b0010, 1'b0, 1'b1, 8'h22);
    exp[8] = pk(4'b0000, 4'b0000, 1'b0, 1'b0, 8'h22);
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req   = 4'b0011;
    for (int t = 1; t <= 8; t++) begin
      tick();
      checks++;
      if (obs !== exp[t]) begin
        errors++;
        $display("FAIL skip_wrap t=%0d: got %h expected %h", t, obs, exp[t]);
      end
      if (t == 7) req = 4'b0000;
    end
  endtask

  task automatic test_early_drop();
    logic [17:0] exp [1:8];
    exp[1] = pk(4'b0100, 4'b0000, 1'b1, 1'b1, 8'h33);
    exp[2] = pk(4'b0100, 4'b0000, 1'b1, 1'b1, 8'h33);
    exp[3] = pk(4'b0100, 4'b0100, 1'b0, 1'b1, 8'h33);
    exp[4] = pk(4'b0000, 4'b0000, 1'b0, 1'b0, 8'h33);
    exp[5] = pk(4'b0010, 4'b0000, 1'b1, 1'b1, 8'h22);
    exp[6] = pk(4'b0010, 4'b0000, 1'b1, 1'b1, 8'h22);
    exp[7] = pk(4'b0010, 4'b0010, 1'b0, 1'b1, 8'h22);
    exp[8] = pk(4'b0000, 4'b0000, 1'b0, 1'b0, 8'h22);
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    req   = 4'b0110;
    for (int t = 1; t <= 8; t++) begin
      tick();
      checks++;
      if (obs !== exp[t]) begin
        errors++;
        $display("FAIL early_drop t=%0d: got %h expected %h", t, obs, exp[t]);
      end
      if (t == 1) req = 4'b0010;
      if (t == 7) req = 4'b0000;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rest   = 1'b1;
    req    = 4'b0000;
    wdata  = '0;
    #1;
    test_reset();
    test_single();
    test_reset_mid_open();
    test_round_robin();
    test_data_capture();
    test_skip_wrap();
    test_early_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
